calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer_pkg.sv | 25 ++
 rtl/calc_sequencer_checker.sv | 23 ++
 rtl/calc_sequencer.sv | 169 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_sequencer_pkg.sv
// Shared constants and FSM encoding for the multiply-free FIR sample sequencer.
// Terms are aligned with ALIGN_LSB_W zero LSBs before accumulation.
package calc_sequencer_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ACC_W_DEFAULT  = 40;
  localparam int ALIGN_LSB_W    = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    TERM_ADD  = 3'd2,
    TERM_WAIT = 3'd3,
    GRP_ADD   = 3'd4,
    GRP_WAIT  = 3'd5,
    SHIFT     = 3'd6,
    DONE      = 3'd7
  } calcState_t;

  // Sign-extension bits needed in front of a sample to fill the accumulator.
  function automatic int signExtWidth(input int accW, input int dataW);
    return accW - ALIGN_LSB_W - dataW;
  endfunction

endpackage

// File: rtl/calc_sequencer_checker.sv
// Protocol invariants of the sequencer handshake outputs; no functional logic.
module calc_sequencer_checker (
  input logic sClk,
  input logic ALUReset,
  input logic addStart,
  input logic resultValid,
  input logic coeffReady,
  input logic calcBusy
);

  addStartSingleCycle: assert property (@(posedge sClk) disable iff (ALUReset)
    addStart |=> !addStart);

  resultValidSingleCycle: assert property (@(posedge sClk) disable iff (ALUReset)
    resultValid |=> !resultValid);

  readyNotDuringAdd: assert property (@(posedge sClk) disable iff (ALUReset)
    !(coeffReady && addStart));

  busyDropsWithResult: assert property (@(posedge sClk) disable iff (ALUReset)
    resultValid |-> !calcBusy);

endmodule

// File: rtl/calc_sequencer.sv
// Sequences signed coefficient terms through an external adder: terms sum into a
// group, each group folds into the accumulator followed by an arithmetic halving.
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ACC_W  = ACC_W_DEFAULT
) (
  input  logic              sClk,
  input  logic              ALUReset,
  input  logic              startCalc,
  input  logic              coeffValid,
  output logic              coeffReady,
  input  logic              coeffSign,
  input  logic [DATA_W-1:0] coeffData,
  input  logic              coeffLast,
  input  logic              groupLast,
  output logic              addStart,
  output logic              addSign,
  output logic [ACC_W-1:0]  addOperandA,
  output logic [ACC_W-1:0]  addOperandB,
  input  logic [ACC_W-1:0]  addResult,
  input  logic              addDone,
  output logic              calcBusy,
  output logic              resultValid,
  output logic [ACC_W-1:0]  calcResult
);

  localparam int SEXT_W = signExtWidth(ACC_W, DATA_W);

  calcState_t       state;
  calcState_t       stateNext;
  logic [ACC_W-1:0] groupSum;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sumLatch;
  logic [ACC_W-1:0] alignedTerm;
  logic [ACC_W-1:0] halvedSum;
  logic             lastFlag;
  logic             groupLastFlag;

  // Operand alignment and arithmetic halving of the latched group total.
  always_comb begin
    alignedTerm = {{SEXT_W{coeffData[DATA_W-1]}}, coeffData, {ALIGN_LSB_W{1'b0}}};
    halvedSum   = {sumLatch[ACC_W-1], sumLatch[ACC_W-1:1]};
  end

  // State register.
  always_ff @(posedge sClk) begin
    if (ALUReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode; addDone only matters in the two wait states.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (startCalc) stateNext = FETCH;
        else           stateNext = IDLE;
      end
      FETCH: begin
        if (coeffValid) stateNext = TERM_ADD;
        else            stateNext = FETCH;
      end
      TERM_ADD: stateNext = TERM_WAIT;
      TERM_WAIT: begin
        if (addDone) begin
          if (lastFlag) stateNext = GRP_ADD;
          else          stateNext = FETCH;
        end else begin
          stateNext = TERM_WAIT;
        end
      end
      GRP_ADD: stateNext = GRP_WAIT;
      GRP_WAIT: begin
        if (addDone) stateNext = SHIFT;
        else         stateNext = GRP_WAIT;
      end
      SHIFT: begin
        if (groupLastFlag) stateNext = DONE;
        else               stateNext = FETCH;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and registered outputs; adder operands are loaded on the edge
  // entering an ADD state so they are stable for the whole request and wait.
  always_ff @(posedge sClk) begin
    if (ALUReset) begin
      groupSum      <= {ACC_W{1'b0}};
      acc           <= {ACC_W{1'b0}};
      sumLatch      <= {ACC_W{1'b0}};
      calcResult    <= {ACC_W{1'b0}};
      addOperandA   <= {ACC_W{1'b0}};
      addOperandB   <= {ACC_W{1'b0}};
      addSign       <= 1'b0;
      addStart      <= 1'b0;
      coeffReady    <= 1'b0;
      calcBusy      <= 1'b0;
      resultValid   <= 1'b0;
      lastFlag      <= 1'b0;
      groupLastFlag <= 1'b0;
    end else begin
      addStart    <= 1'b0;
      resultValid <= 1'b0;
      coeffReady  <= (stateNext == FETCH);
      case (state)
        IDLE: begin
          if (startCalc) begin
            groupSum <= {ACC_W{1'b0}};
            acc      <= {ACC_W{1'b0}};
            calcBusy <= 1'b1;
          end
        end
        FETCH: begin
          if (coeffValid) begin
            lastFlag      <= coeffLast;
            groupLastFlag <= coeffLast & groupLast;
            addOperandA   <= alignedTerm;
            addOperandB   <= groupSum;
            addSign       <= coeffSign;
            addStart      <= 1'b1;
          end
        end
        TERM_WAIT: begin
          if (addDone) begin
            groupSum <= addResult;
            if (lastFlag) begin
              addOperandA <= addResult;
              addOperandB <= acc;
              addSign     <= 1'b0;
              addStart    <= 1'b1;
            end
          end
        end
        GRP_WAIT: begin
          if (addDone) sumLatch <= addResult;
        end
        SHIFT: begin
          acc      <= halvedSum;
          groupSum <= {ACC_W{1'b0}};
        end
        DONE: begin
          calcResult  <= acc;
          resultValid <= 1'b1;
          calcBusy    <= 1'b0;
        end
        default: begin
          addStart <= 1'b0;
        end
      endcase
    end
  end

  calc_sequencer_checker uChecker (
    .sClk        (sClk),
    .ALUReset    (ALUReset),
    .addStart    (addStart),
    .resultValid (resultValid),
    .coeffReady  (coeffReady),
    .calcBusy    (calcBusy)
  );

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural external adder whose
// completion latency is programmable.
module tb_calc_sequencer;

  logic        sClk = 1'b0;
  logic        ALUReset;
  logic        startCalc;
  logic        coeffValid;
  logic        coeffReady;
  logic        coeffSign;
  logic [15:0] coeffData;
  logic        coeffLast;
  logic        groupLast;
  logic        addStart;
  logic        addSign;
  logic [39:0] addOperandA;
  logic [39:0] addOperandB;
  logic [39:0] addResult = 40'd0;
  logic        addDone = 1'b0;
  logic        calcBusy;
  logic        resultValid;
  logic [39:0] calcResult;

  int assertCount = 0;
  int failCount   = 0;
  int rvCount     = 0;
  int asCount     = 0;
  logic [39:0] lastOpB = 40'd0;

  int          addDelay = 0;
  logic        pending = 1'b0;
  int          delayCnt = 0;
  logic [39:0] pendRes = 40'd0;

  logic        wSign [8];
  logic [15:0] wData [8];
  logic        wLast [8];
  logic        wGlast[8];

  always #5 sClk = ~sClk;

  calc_sequencer dut (
    .sClk        (sClk),
    .ALUReset    (ALUReset),
    .startCalc   (startCalc),
    .coeffValid  (coeffValid),
    .coeffReady  (coeffReady),
    .coeffSign   (coeffSign),
    .coeffData   (coeffData),
    .coeffLast   (coeffLast),
    .groupLast   (groupLast),
    .addStart    (addStart),
    .addSign     (addSign),
    .addOperandA (addOperandA),
    .addOperandB (addOperandB),
    .addResult   (addResult),
    .addDone     (addDone),
    .calcBusy    (calcBusy),
    .resultValid (resultValid),
    .calcResult  (calcResult)
  );

  // External adder: one request, one result pulse addDelay cycles later.
  always @(posedge sClk) begin
    addDone <= 1'b0;
    if (pending) begin
      if (delayCnt == 0) begin
        addDone   <= 1'b1;
        addResult <= pendRes;
        pending   <= 1'b0;
      end else begin
        delayCnt <= delayCnt - 1;
      end
    end
    if (addStart === 1'b1) begin
      pending  <= 1'b1;
      delayCnt <= addDelay;
      pendRes  <= addSign ? (addOperandB - addOperandA) : (addOperandA + addOperandB);
    end
  end

  always @(negedge sClk) begin
    if (resultValid === 1'b1) rvCount <= rvCount + 1;
    if (addStart === 1'b1) begin
      asCount <= asCount + 1;
      lastOpB <= addOperandB;
    end
  end

  task automatic checkValue(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setWord(input int i, input logic s, input logic [15:0] d, input logic l, input logic g);
    wSign[i] = s; wData[i] = d; wLast[i] = l; wGlast[i] = g;
  endtask

  task automatic sendWord(input int i);
    int waitCyc = 0;
    while (coeffReady !== 1'b1 && waitCyc < 100) begin
      @(negedge sClk);
      waitCyc++;
    end
    if (coeffReady !== 1'b1) begin
      checkValue("coeffReady timeout", {39'd0, coeffReady}, 40'd1);
    end else begin
      coeffValid = 1'b1;
      coeffSign  = wSign[i];
      coeffData  = wData[i];
      coeffLast  = wLast[i];
      groupLast  = wGlast[i];
      @(negedge sClk);
      coeffValid = 1'b0;
      coeffLast  = 1'b0;
      groupLast  = 1'b0;
    end
  endtask

  task automatic runCalc(input string tag, input int n, input bit pokeStart,
                         input int expAdds, input logic [39:0] expected);
    int rv0 = rvCount;
    int as0 = asCount;
    int waitCyc = 0;
    startCalc = 1'b1;
    @(negedge sClk);
    startCalc = 1'b0;
    checkValue({tag, " busy"}, {39'd0, calcBusy}, 40'd1);
    for (int i = 0; i < n; i++) begin
      sendWord(i);
      if (pokeStart && i == 0) begin
        startCalc = 1'b1;
        @(negedge sClk);
        startCalc = 1'b0;
      end
    end
    while (resultValid !== 1'b1 && waitCyc < 300) begin
      @(negedge sClk);
      waitCyc++;
    end
    checkValue({tag, " resultValid"}, {39'd0, resultValid}, 40'd1);
    checkValue({tag, " calcResult"}, calcResult, expected);
    repeat (3) @(negedge sClk);
    checkValue({tag, " pulses"}, 40'(rvCount - rv0), 40'd1);
    checkValue({tag, " addStarts"}, 40'(asCount - as0), 40'(expAdds));
    checkValue({tag, " idle"}, {39'd0, calcBusy}, 40'd0);
  endtask

  initial begin
    int rv0;
    ALUReset = 1'b1; startCalc = 1'b0; coeffValid = 1'b0; coeffSign = 1'b0;
    coeffData = 16'h0000; coeffLast = 1'b0; groupLast = 1'b0;
    repeat (3) @(negedge sClk);
    checkValue("rst calcResult", calcResult, 40'd0);
    checkValue("rst opA", addOperandA, 40'd0);
    checkValue("rst opB", addOperandB, 40'd0);
    checkValue("rst flags", {35'd0, addStart, addSign, coeffReady, calcBusy, resultValid}, 40'd0);
    ALUReset = 1'b0;
    @(negedge sClk);

    setWord(0, 1'b0, 16'h0100, 1'b0, 1'b0);
    setWord(1, 1'b0, 16'h0200, 1'b1, 1'b1);
    runCalc("twoTerms", 2, 1'b0, 3, 40'h00_0180_0000);

    setWord(0, 1'b1, 16'h0100, 1'b1, 1'b1);
    runCalc("negTerm", 1, 1'b0, 2, 40'hFF_FF80_0000);

    setWord(0, 1'b0, 16'h0100, 1'b1, 1'b0);
    setWord(1, 1'b0, 16'h0100, 1'b1, 1'b1);
    runCalc("twoGroups", 2, 1'b0, 4, 40'h00_00C0_0000);
    checkValue("twoGroups acc1", lastOpB, 40'h00_0080_0000);

    setWord(0, 1'b1, 16'h8000, 1'b1, 1'b1);
    runCalc("mostNeg", 1, 1'b0, 2, 40'h00_4000_0000);

    setWord(0, 1'b0, 16'h0100, 1'b0, 1'b1);
    setWord(1, 1'b0, 16'h0100, 1'b1, 1'b1);
    runCalc("glastNoLast", 2, 1'b0, 3, 40'h00_0100_0000);

    addDelay = 5;
    setWord(0, 1'b0, 16'h0100, 1'b0, 1'b0);
    setWord(1, 1'b0, 16'h0200, 1'b1, 1'b1);
    runCalc("stall", 2, 1'b1, 3, 40'h00_0180_0000);

    rv0 = rvCount;
    startCalc = 1'b1;
    @(negedge sClk);
    startCalc = 1'b0;
    setWord(0, 1'b1, 16'h0100, 1'b1, 1'b1);
    sendWord(0);
    @(negedge sClk);
    ALUReset = 1'b1;
    @(negedge sClk);
    ALUReset = 1'b0;
    checkValue("abort calcResult", calcResult, 40'd0);
    checkValue("abort opA", addOperandA, 40'd0);
    checkValue("abort opB", addOperandB, 40'd0);
    checkValue("abort flags", {35'd0, addStart, addSign, coeffReady, calcBusy, resultValid}, 40'd0);
    repeat (12) @(negedge sClk);
    checkValue("abort no result", 40'(rvCount - rv0), 40'd0);
    checkValue("abort still idle", {38'd0, calcBusy, coeffReady}, 40'd0);
    addDelay = 0;
    runCalc("afterAbort", 1, 1'b0, 2, 40'hFF_FF80_0000);

    ALUReset = 1'b1;
    startCalc = 1'b1;
    @(negedge sClk);
    ALUReset = 1'b0;
    startCalc = 1'b0;
    @(negedge sClk);
    checkValue("rst beats start", {38'd0, calcBusy, coeffReady}, 40'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
